dac_parallel_tx: RTL and testbench

Transmit-side counterpart of the team's ADC clock/capture block. It accepts samples on a valid/ready stream and buffers them in a small FIFO. It generates the converter sample clock by integer division of clk and drives a parallel DAC data bus, updating data on the falling edge of the generated clock so it is stable at the DAC's rising-edge latch. It sits between the DSP/DMA stream and the DAC pins.

---
 rtl/dac_tx_pkg.sv | 17 +
 rtl/dac_tx_fifo.sv | 50 +++++
 rtl/dac_parallel_tx.sv | 121 ++++++++++++
 tb/tb_dac_parallel_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the parallel DAC transmit path.
package dac_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } tx_state_t;

   localparam int UNDERRUN_CNT_W = 16;

   // Offset-binary mid-scale code for a w-bit converter (MSB set, rest clear).
   function automatic logic [31:0] midscale(input int unsigned w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Registered sample FIFO: a push in cycle N is visible to pop from cycle N+1.
module dac_tx_fifo #(
   parameter  int DATA_W = 12,
   parameter  int DEPTH  = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Storage array; no reset needed, occupancy tracking guards reads.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_parallel_tx.sv
// Stream-fed parallel DAC driver: divides clk into dac_clk and updates the
// data bus on dac_clk falling edges so it is settled at the DAC's rising latch.
module dac_parallel_tx
   import dac_tx_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int CNT_W      = 12,
   parameter int FIFO_DEPTH = 16,
   parameter int PRIME_LVL  = 4,
   parameter bit TWOS_COMP  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [CNT_W-1:0]          cnt_reg,
   input  logic [DATA_W-1:0]         s_data,
   input  logic                      s_valid,
   output logic                      s_ready,
   output logic                      dac_clk,
   output logic [DATA_W-1:0]         dac_data,
   output logic                      sample_stb,
   output logic                      underrun,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));
   // Flipping the MSB maps two's complement onto offset binary.
   localparam logic [DATA_W-1:0] CONV_MASK = TWOS_COMP ? MIDSCALE : '0;

   tx_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt_l, div_cnt;
   logic [DATA_W-1:0] fifo_rdata;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_full, fifo_empty;
   logic              run_act, tick, fall_tick, pop;

   // Divider only advances while running and still enabled; dropping en
   // takes effect on the very next edge, so no pop may happen on that edge.
   assign run_act   = (state == RUN) && en;
   assign tick      = run_act && (div_cnt == cnt_l);
   assign fall_tick = tick && dac_clk;
   assign pop       = fall_tick && !fifo_empty;
   assign s_ready   = !fifo_full;

   dac_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s_valid),
      .wdata (s_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state: prime until enough samples are buffered, then run.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (en) state_nxt = PRIME;
         PRIME:   if (!en) state_nxt = IDLE;
                  else if (fifo_level >= LVL_W'(PRIME_LVL)) state_nxt = RUN;
         RUN:     if (!en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Divide value is captured only when leaving IDLE so dac_clk never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  cnt_l <= '0;
      else if (state == IDLE && en) cnt_l <= cnt_reg;
   end

   // Half-period divider and generated clock; parked low outside RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         dac_clk <= 1'b0;
      end else if (run_act) begin
         div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
         if (tick) dac_clk <= !dac_clk;
      end else begin
         div_cnt <= '0;
         dac_clk <= 1'b0;
      end
   end

   // Output data register and per-update strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_data   <= MIDSCALE;
         sample_stb <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         sample_stb <= pop;
         underrun   <= fall_tick && fifo_empty;
         if (!run_act)  dac_data <= MIDSCALE;
         else if (pop)  dac_data <= fifo_rdata ^ CONV_MASK;
      end
   end

   // Saturating underrun counter, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         underrun_cnt <= '0;
      else if (fall_tick && fifo_empty && (underrun_cnt != '1))
         underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
   end

endmodule

// File: tb/tb_dac_parallel_tx.sv
// Directed bench for dac_parallel_tx with a cycle-level reference model.
module tb_dac_parallel_tx;

   localparam int DEPTH = 16;
   localparam int PLVL  = 4;
   localparam logic [11:0] MID = 12'h800;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic [11:0] cnt_reg = '0;
   logic [11:0] s_data = '0;
   logic        s_valid = 1'b0;

   logic        s_ready, dac_clk, sample_stb, underrun;
   logic [11:0] dac_data;
   logic [15:0] underrun_cnt;
   logic        s_ready2, dac_clk2, sample_stb2, underrun2;
   logic [11:0] dac_data2;
   logic [15:0] underrun_cnt2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dac_parallel_tx dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt_reg(cnt_reg),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .dac_clk(dac_clk), .dac_data(dac_data), .sample_stb(sample_stb),
      .underrun(underrun), .underrun_cnt(underrun_cnt)
   );

   dac_parallel_tx #(.TWOS_COMP(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt_reg(cnt_reg),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
      .dac_clk(dac_clk2), .dac_data(dac_data2), .sample_stb(sample_stb2),
      .underrun(underrun2), .underrun_cnt(underrun_cnt2)
   );

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   // Mode: 0 stopped, 1 waiting for PLVL samples, 2 running. While running,
   // the n-th clk edge is a half-period boundary when n is a multiple of
   // (cnt+1); odd boundaries raise dac_clk, even ones lower it and consume.
   int          m_mode = 0, m_cnt = 0, m_n = 0, m_k = 0, m_lvl = 0, m_ucnt = 0;
   bit          m_acc;
   logic        m_clk = 1'b0, m_stb = 1'b0, m_und = 1'b0;
   logic [11:0] m_data = MID, m_data2 = MID, m_v;
   logic [11:0] q[$];

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_mode = 0; m_n = 0; m_clk = 0; m_data = MID; m_data2 = MID;
            m_stb = 0; m_und = 0; m_ucnt = 0; q.delete();
         end else begin
            m_lvl = q.size();
            m_acc = s_valid && (m_lvl < DEPTH);
            m_stb = 0; m_und = 0;
            if (m_mode == 0) begin
               if (en) begin m_cnt = int'(cnt_reg); m_mode = 1; end
            end else if (m_mode == 1) begin
               if (!en) m_mode = 0;
               else if (m_lvl >= PLVL) begin m_mode = 2; m_n = 0; end
            end else begin
               if (!en) begin
                  m_mode = 0; m_clk = 0; m_data = MID; m_data2 = MID;
               end else begin
                  m_n++;
                  if (m_n % (m_cnt + 1) == 0) begin
                     m_k = m_n / (m_cnt + 1);
                     m_clk = (m_k % 2 == 1);
                     if (m_k % 2 == 0) begin
                        if (m_lvl > 0) begin
                           m_v = q.pop_front();
                           m_data = m_v; m_data2 = m_v ^ MID; m_stb = 1;
                        end else begin
                           m_und = 1;
                           if (m_ucnt < 65535) m_ucnt++;
                        end
                     end
                  end
               end
            end
            if (m_acc) q.push_back(s_data);
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("s_ready", s_ready, q.size() < DEPTH);
         chk("dac_clk", dac_clk, m_clk);
         chk("dac_data", dac_data, m_data);
         chk("sample_stb", sample_stb, m_stb);
         chk("underrun", underrun, m_und);
         chk("underrun_cnt", underrun_cnt, m_ucnt);
         chk("dac_clk_2c", dac_clk2, m_clk);
         chk("dac_data_2c", dac_data2, m_data2);
         chk("s_ready_2c", s_ready2, q.size() < DEPTH);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [11:0] cap[$], cap2[$];

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [11:0] d);
      s_data = d; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; s_valid = 1'b0; rst_n = 1'b0;
      #3 rst_n = 1'b1;
      step();
   endtask

   // Collect n data-bus updates (bounded); ends on a negedge.
   task automatic wait_stb(input int n, input string nm);
      int got = 0;
      for (int c = 0; c < 400 && got < n; c++) begin
         @(negedge clk);
         if (sample_stb) begin
            got++;
            cap.push_back(dac_data);
            cap2.push_back(dac_data2);
         end
      end
      chk(nm, got, n);
   endtask

   task automatic wait_und(input string nm);
      bit seen = 0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (underrun) seen = 1;
      end
      chk(nm, seen, 1);
   endtask

   // Measure one full dac_clk high phase followed by a low phase.
   task automatic measure(input int eh, input int el, input string nm);
      int hi = 0, lo = 0, c = 0;
      do begin @(negedge clk); c++; end while (dac_clk && c < 100);
      do begin @(negedge clk); c++; end while (!dac_clk && c < 200);
      while (dac_clk && c < 300) begin hi++; @(negedge clk); c++; end
      while (!dac_clk && c < 400) begin lo++; @(negedge clk); c++; end
      chk({nm, "_high"}, hi, eh);
      chk({nm, "_low"}, lo, el);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_dac_clk", dac_clk, 0);
      chk("rst_dac_data", dac_data, 12'h800);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_ucnt", underrun_cnt, 0);
      chk("rst_stb", sample_stb, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();

      // Fastest divide: four samples, then one underrun.
      cnt_reg = 12'd0;
      for (int i = 1; i <= 4; i++) push(12'(i));
      cap.delete(); cap2.delete();
      en = 1'b1;
      wait_stb(4, "t1_stb_count");
      for (int i = 0; i < 4 && i < cap.size(); i++) chk("t1_seq", cap[i], 12'(i + 1));
      wait_und("t1_underrun");
      chk("t1_hold_data", dac_data, 12'h004);
      chk("t1_ucnt", underrun_cnt, 16'd1);
      @(negedge clk); en = 1'b0;
      step();

      // Half-period 4, divider change mid-run must be ignored.
      do_reset();
      for (int i = 0; i < 16; i++) push(12'h100 + 12'(i));
      cnt_reg = 12'd3;
      en = 1'b1;
      measure(4, 4, "t2_period");
      cnt_reg = 12'd7;
      measure(4, 4, "t2_period_after_write");

      // Two's-complement conversion on the second instance.
      do_reset();
      cnt_reg = 12'd0;
      push(12'h800); push(12'h7FF); push(12'h000); push(12'h123);
      cap.delete(); cap2.delete();
      en = 1'b1;
      wait_stb(3, "t3_stb_count");
      if (cap2.size() >= 3) begin
         chk("t3_2c_a", cap2[0], 12'h000);
         chk("t3_2c_b", cap2[1], 12'hFFF);
         chk("t3_2c_c", cap2[2], 12'h800);
         chk("t3_ob_b", cap[1], 12'h7FF);
      end

      // Fill to full with the block stopped; 17th sample rejected.
      do_reset();
      for (int i = 0; i < 16; i++) push(12'h300 + 12'(i));
      chk("t4_full_ready", s_ready, 0);
      push(12'h0AA);
      cap.delete(); cap2.delete();
      cnt_reg = 12'd0;
      en = 1'b1;
      wait_stb(1, "t4_first_pop");
      chk("t4_ready_after_pop", s_ready, 1);
      wait_stb(15, "t4_drain");
      for (int i = 0; i < 16 && i < cap.size(); i++) chk("t4_order", cap[i], 12'h300 + 12'(i));
      wait_und("t4_underrun");
      @(negedge clk); en = 1'b0;
      step();

      // Drop en with five samples buffered; they must survive a restart.
      do_reset();
      for (int i = 0; i < 9; i++) push(12'h200 + 12'(i));
      cnt_reg = 12'd0;
      cap.delete(); cap2.delete();
      en = 1'b1;
      wait_stb(4, "t5_first_four");
      en = 1'b0;
      @(negedge clk);
      chk("t5_stop_clk", dac_clk, 0);
      chk("t5_stop_data", dac_data, 12'h800);
      cap.delete(); cap2.delete();
      en = 1'b1;
      wait_stb(5, "t5_retained");
      for (int i = 0; i < 5 && i < cap.size(); i++) chk("t5_order", cap[i], 12'h204 + 12'(i));

      // Asynchronous reset between clock edges.
      wait_und("t6_underrun");
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("t6_dac_clk", dac_clk, 0);
      chk("t6_dac_data", dac_data, 12'h800);
      chk("t6_ucnt", underrun_cnt, 0);
      chk("t6_s_ready", s_ready, 1);
      chk("t6_stb", sample_stb, 0);
      chk("t6_underrun", underrun, 0);
      en = 1'b0;
      #1 rst_n = 1'b1;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
